// File: rtl/wb_stage.sv
// Write-back stage: registers the MEM->WB bundle, selects and aligns the write data,
// drives the register-file write port and absorbs variable-latency IO reads.
module wb_stage #(
  parameter int IO_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu,
  input  logic [1:0]  in_wb_sel,
  input  logic [1:0]  in_dout_sel,
  input  logic [3:0]  in_mask,
  input  logic        in_mask_un,
  input  logic        in_regwen,
  input  logic [4:0]  in_rd,
  input  logic [31:0] dmem_dout,
  input  logic [31:0] bios_dout,
  input  logic [31:0] io_rdata,
  input  logic        io_rvalid,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        stall,
  output logic        io_err
);

  localparam logic [1:0] WB_MEM    = 2'd0;
  localparam logic [1:0] WB_ALU    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;
  localparam logic [1:0] DOUT_DMEM = 2'd0;
  localparam logic [1:0] DOUT_BIOS = 2'd1;
  localparam logic [1:0] DOUT_IO   = 2'd2;
  localparam logic [7:0] TIMEOUT_CNT = 8'(IO_TIMEOUT);

  typedef enum logic {ST_RUN, ST_WAIT_IO} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        valid_q;
  logic [31:0] pc_q, alu_q;
  logic [1:0]  wb_sel_q, dout_sel_q;
  logic [3:0]  mask_q;
  logic        mask_un_q, regwen_q;
  logic [4:0]  rd_q;

  logic        commit, zero_wd, is_io_load;
  logic [31:0] raw_word, load_word;

  function automatic logic [31:0] align_load(input logic [31:0] raw,
                                             input logic [3:0] mask,
                                             input logic un);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic        [31:0] res;
    b   = 8'd0;
    h   = 16'd0;
    res = 32'd0;
    case (mask)
      4'b0001: b = raw[7:0];
      4'b0010: b = raw[15:8];
      4'b0100: b = raw[23:16];
      4'b1000: b = raw[31:24];
      4'b0011: h = raw[15:0];
      4'b1100: h = raw[31:16];
      default: ;
    endcase
    b_s = b;
    h_s = h;
    case (mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: res = un ? {24'd0, b} : 32'(b_s);
      4'b0011, 4'b1100:                   res = un ? {16'd0, h} : 32'(h_s);
      4'b1111:                            res = raw;
      default:                            res = 32'd0;
    endcase
    return res;
  endfunction

  // Control state: valid, FSM, timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      state_q <= ST_RUN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!stall) valid_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      pc_q       <= in_pc;
      alu_q      <= in_alu;
      wb_sel_q   <= in_wb_sel;
      dout_sel_q <= in_dout_sel;
      mask_q     <= in_mask;
      mask_un_q  <= in_mask_un;
      regwen_q   <= in_regwen;
      rd_q       <= in_rd;
    end
  end

  assign is_io_load = valid_q && (wb_sel_q == WB_MEM) && (dout_sel_q == DOUT_IO);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    io_err  = 1'b0;
    commit  = 1'b0;
    zero_wd = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (is_io_load && !io_rvalid) begin
          stall   = 1'b1;
          state_d = ST_WAIT_IO;
          cnt_d   = 8'd0;
        end else begin
          commit = 1'b1;
        end
      end
      ST_WAIT_IO: begin
        cnt_d = cnt_q + 8'd1;
        // Data arriving on the timeout cycle still wins over the error
        if (io_rvalid) begin
          commit  = 1'b1;
          state_d = ST_RUN;
        end else if (cnt_q == TIMEOUT_CNT) begin
          commit  = 1'b1;
          zero_wd = 1'b1;
          io_err  = 1'b1;
          state_d = ST_RUN;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    case (dout_sel_q)
      DOUT_DMEM: raw_word = dmem_dout;
      DOUT_BIOS: raw_word = bios_dout;
      DOUT_IO:   raw_word = io_rdata;
      default:   raw_word = 32'd0;
    endcase
  end

  assign load_word = align_load(raw_word, mask_q, mask_un_q);

  always_comb begin
    rf_wd = 32'd0;
    if (!zero_wd) begin
      case (wb_sel_q)
        WB_MEM:  rf_wd = load_word;
        WB_ALU:  rf_wd = alu_q;
        WB_PC4:  rf_wd = pc_q + 32'd4;
        default: rf_wd = 32'd0;
      endcase
    end
  end

  assign rf_we = valid_q && regwen_q && (rd_q != 5'd0) && commit;
  assign rf_wa = rd_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed cases from the stage's behaviour plus randomized
// non-stalling instructions checked against an arithmetic reference model.
module tb_wb_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_pc, in_alu;
  logic [1:0]  in_wb_sel, in_dout_sel;
  logic [3:0]  in_mask;
  logic        in_mask_un, in_regwen;
  logic [4:0]  in_rd;
  logic [31:0] dmem_dout, bios_dout, io_rdata;
  logic        io_rvalid;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        stall, io_err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  wb_stage #(.IO_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_pc(in_pc), .in_alu(in_alu),
    .in_wb_sel(in_wb_sel), .in_dout_sel(in_dout_sel), .in_mask(in_mask),
    .in_mask_un(in_mask_un), .in_regwen(in_regwen), .in_rd(in_rd),
    .dmem_dout(dmem_dout), .bios_dout(bios_dout),
    .io_rdata(io_rdata), .io_rvalid(io_rvalid),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .stall(stall), .io_err(io_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                           input logic [1:0] wsel, input logic [1:0] dsel,
                           input logic [3:0] m, input logic un, input logic we,
                           input logic [4:0] rd);
    in_valid = v; in_pc = pc; in_alu = alu; in_wb_sel = wsel; in_dout_sel = dsel;
    in_mask = m; in_mask_un = un; in_regwen = we; in_rd = rd;
  endtask

  // Reference: pick a lane by position, then extend arithmetically
  function automatic logic [31:0] ref_load(input logic [31:0] raw, input logic [3:0] m,
                                           input logic un);
    int lo, n;
    longint v;
    case (m)
      4'b0001: begin lo = 0; n = 1; end
      4'b0010: begin lo = 1; n = 1; end
      4'b0100: begin lo = 2; n = 1; end
      4'b1000: begin lo = 3; n = 1; end
      4'b0011: begin lo = 0; n = 2; end
      4'b1100: begin lo = 2; n = 2; end
      4'b1111: begin lo = 0; n = 4; end
      default: return 32'd0;
    endcase
    v = longint'((64'(raw) >> (8 * lo)) & ((64'd1 << (8 * n)) - 64'd1));
    if (!un && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_wd(input logic [1:0] wsel, input logic [1:0] dsel,
                                         input logic [3:0] m, input logic un,
                                         input logic [31:0] pc, input logic [31:0] alu,
                                         input logic [31:0] dm, input logic [31:0] bi,
                                         input logic [31:0] io);
    logic [31:0] raw;
    raw = (dsel == 2'd0) ? dm : (dsel == 2'd1) ? bi : (dsel == 2'd2) ? io : 32'd0;
    if (wsel == 2'd1) return alu;
    if (wsel == 2'd2) return pc + 32'd4;
    return ref_load(raw, m, un);
  endfunction

  initial begin
    int nst, errs;
    logic done;
    logic [31:0] exp_wd;
    logic exp_we;

    rst_n = 1'b0;
    set_instr(1'b1, 32'h0, 32'h5, 2'd1, 2'd0, 4'hF, 1'b0, 1'b1, 5'd3);
    dmem_dout = 32'h0; bios_dout = 32'h0; io_rdata = 32'h0; io_rvalid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("reset_we", 32'(rf_we), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_err", 32'(io_err), 32'd0);
    rst_n = 1'b1;

    // ADDI x3
    set_instr(1'b1, 32'h0, 32'h5, 2'd1, 2'd0, 4'hF, 1'b0, 1'b1, 5'd3);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("addi_we", 32'(rf_we), 32'd1);
    chk("addi_wa", 32'(rf_wa), 32'd3);
    chk("addi_wd", rf_wd, 32'd5);
    chk("addi_stall", 32'(stall), 32'd0);

    // LB / LBU
    set_instr(1'b1, 32'h0, 32'h2, 2'd0, 2'd0, 4'b0100, 1'b0, 1'b1, 5'd4);
    tick(); in_valid = 1'b0; dmem_dout = 32'h80FF_7F01;
    @(negedge clk); chk("lb_b2", rf_wd, 32'hFFFF_FFFF);
    set_instr(1'b1, 32'h0, 32'h3, 2'd0, 2'd0, 4'b1000, 1'b0, 1'b1, 5'd4);
    tick(); in_valid = 1'b0;
    @(negedge clk); chk("lb_b3", rf_wd, 32'hFFFF_FF80);
    set_instr(1'b1, 32'h0, 32'h3, 2'd0, 2'd0, 4'b1000, 1'b1, 1'b1, 5'd4);
    tick(); in_valid = 1'b0;
    @(negedge clk); chk("lbu_b3", rf_wd, 32'h0000_0080);

    // LH / LHU / null mask
    set_instr(1'b1, 32'h0, 32'h2, 2'd0, 2'd0, 4'b1100, 1'b0, 1'b1, 5'd6);
    tick(); in_valid = 1'b0; dmem_dout = 32'h8001_7FFF;
    @(negedge clk); chk("lh_hi", rf_wd, 32'hFFFF_8001);
    set_instr(1'b1, 32'h0, 32'h2, 2'd0, 2'd0, 4'b1100, 1'b1, 1'b1, 5'd6);
    tick(); in_valid = 1'b0;
    @(negedge clk); chk("lhu_hi", rf_wd, 32'h0000_8001);
    set_instr(1'b1, 32'h0, 32'h2, 2'd0, 2'd0, 4'b0000, 1'b0, 1'b1, 5'd6);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("mask0_wd", rf_wd, 32'd0);
    chk("mask0_we", 32'(rf_we), 32'd1);

    // JAL to x0 and to x1
    set_instr(1'b1, 32'h1000_0010, 32'h0, 2'd2, 2'd0, 4'hF, 1'b0, 1'b1, 5'd0);
    tick(); in_valid = 1'b0;
    @(negedge clk); chk("jal_x0_we", 32'(rf_we), 32'd0);
    set_instr(1'b1, 32'h1000_0010, 32'h0, 2'd2, 2'd0, 4'hF, 1'b0, 1'b1, 5'd1);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("jal_x1_we", 32'(rf_we), 32'd1);
    chk("jal_x1_wd", rf_wd, 32'h1000_0014);

    // IO load answered on the fourth WB cycle, ADDI queued behind it
    set_instr(1'b1, 32'h0, 32'h8000_0000, 2'd0, 2'd2, 4'hF, 1'b0, 1'b1, 5'd5);
    io_rvalid = 1'b0;
    tick();
    set_instr(1'b1, 32'h0, 32'h0000_ABCD, 2'd1, 2'd0, 4'hF, 1'b0, 1'b1, 5'd9);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("io_wait%0d_stall", c), 32'(stall), 32'd1);
      chk($sformatf("io_wait%0d_we", c), 32'(rf_we), 32'd0);
      tick();
    end
    io_rvalid = 1'b1; io_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("io_done_stall", 32'(stall), 32'd0);
    chk("io_done_we", 32'(rf_we), 32'd1);
    chk("io_done_wa", 32'(rf_wa), 32'd5);
    chk("io_done_wd", rf_wd, 32'h1234_5678);
    chk("io_done_err", 32'(io_err), 32'd0);
    tick(); io_rvalid = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("after_io_we", 32'(rf_we), 32'd1);
    chk("after_io_wa", 32'(rf_wa), 32'd9);
    chk("after_io_wd", rf_wd, 32'h0000_ABCD);

    // IO timeout
    set_instr(1'b1, 32'h0, 32'h8000_0004, 2'd0, 2'd2, 4'hF, 1'b0, 1'b1, 5'd7);
    io_rdata = 32'hDEAD_BEEF;
    tick(); in_valid = 1'b0;
    nst = 0; errs = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stall) begin
        nst++;
        if (io_err) errs++;
        tick();
      end else begin
        done = 1'b1;
      end
    end
    chk("to_ended", 32'(done), 32'd1);
    chk("to_stall_cycles", 32'(nst), 32'(TO + 1));
    chk("to_we", 32'(rf_we), 32'd1);
    chk("to_wd", rf_wd, 32'd0);
    chk("to_err", 32'(io_err), 32'd1);
    errs += int'(io_err);
    tick();
    @(negedge clk);
    errs += int'(io_err);
    chk("to_err_pulses", 32'(errs), 32'd1);

    // Reset while waiting on a second IO load
    set_instr(1'b1, 32'h0, 32'h8000_0008, 2'd0, 2'd2, 4'hF, 1'b0, 1'b1, 5'd8);
    tick(); in_valid = 1'b0;
    @(negedge clk); chk("rw_stall0", 32'(stall), 32'd1);
    tick();
    @(negedge clk); chk("rw_stall1", 32'(stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_rst_stall", 32'(stall), 32'd0);
    chk("rw_rst_we", 32'(rf_we), 32'd0);
    chk("rw_rst_err", 32'(io_err), 32'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("rw_post_we", 32'(rf_we), 32'd0);
    chk("rw_post_stall", 32'(stall), 32'd0);

    // Randomized non-stalling traffic
    io_rvalid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      set_instr(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 2)),
                2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)));
      if (k % 3 == 0) in_mask = (k % 2 == 0) ? 4'b0010 : 4'b1100;
      exp_we = in_valid && in_regwen && (in_rd != 5'd0);
      tick();
      dmem_dout = $urandom; bios_dout = $urandom; io_rdata = $urandom;
      exp_wd = ref_wd(in_wb_sel, in_dout_sel, in_mask, in_mask_un, in_pc, in_alu,
                      dmem_dout, bios_dout, io_rdata);
      @(negedge clk);
      chk($sformatf("rnd%0d_we", k), 32'(rf_we), 32'(exp_we));
      chk($sformatf("rnd%0d_wa", k), 32'(rf_wa), 32'(in_rd));
      chk($sformatf("rnd%0d_wd", k), rf_wd, exp_wd);
      chk($sformatf("rnd%0d_stall", k), 32'(stall), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Final pipeline stage of the RISC-V core. Registers the MEM→WB bundle, selects the write-back source, aligns and sign/zero-extends load data, and drives the register-file write port and the forwarding bus. It absorbs variable-latency IO reads: it stalls the pipeline until the data arrives or a timeout expires.

## Interface
Parameters:
- `IO_TIMEOUT`, default 255: maximum number of cycles spent waiting for IO read data; 8-bit counter range.

Ports:
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: the MEM stage holds a real instruction.
- `in_pc` in 32: PC of that instruction.
- `in_alu` in 32: ALU result, which is also the load address.
- `in_wb_sel` in 2: write-back source. 0 = MEM, 1 = ALU, 2 = PC+4.
- `in_dout_sel` in 2: load source. 0 = DMEM, 1 = BIOS, 2 = IO.
- `in_mask` in 4: byte-lane mask for loads.
- `in_mask_un` in 1: zero-extend when 1, sign-extend when 0.
- `in_regwen` in 1: instruction writes rd.
- `in_rd` in 5: destination register.
- `dmem_dout` in 32: DMEM read word, valid in the WB cycle.
- `bios_dout` in 32: BIOS read word, valid in the WB cycle.
- `io_rdata` in 32: IO read word.
- `io_rvalid` in 1: `io_rdata` is valid this cycle.
- `rf_we` out 1: register-file write enable.
- `rf_wa` out 5: register-file write address.
- `rf_wd` out 32: register-file write data.
- `stall` out 1: freeze every upstream stage this cycle.
- `io_err` out 1: one-cycle pulse when an IO read times out.

## Operation
- **WB register.** Holds valid, pc, alu, wb_sel, dout_sel, mask, mask_un, regwen and rd. It loads the `in_*` values on each edge where `stall`=0 and holds while `stall`=1.
- **Source select** (from the WB register):
  - ALU: rf_wd = alu.
  - PC+4: rf_wd = pc + 4, modulo 2^32.
  - MEM: rf_wd = aligned load word. The raw word is dmem, bios or io according to dout_sel; dout_sel = 3 gives a raw word of 0.
- **Alignment.**
  - Mask 0001, 0010, 0100, 1000: byte 0, 1, 2 or 3 respectively, moved to bits [7:0].
  - Mask 0011 or 1100: bits [15:0] or [31:16] respectively, moved to bits [15:0].
  - Mask 1111: the whole word.
  - Any other mask, including 0000: rf_wd = 0, while rf_we still follows the normal rule.
  - Upper bits are sign-extended when mask_un = 0 and zero-filled when mask_un = 1. Zero-fill applies only to byte and halfword masks.
- **Write enable.** rf_we = valid & regwen & (rd ≠ 0) & (state = RUN, or state = WAIT_IO with io_rvalid = 1, or timeout). rf_wa = rd at all times.
- **FSM, states RUN and WAIT_IO:**
  - RUN → WAIT_IO when the WB register holds valid & wb_sel = MEM & dout_sel = IO & io_rvalid = 0. The write is withheld and the counter is cleared to 0.
  - In RUN with io_rvalid = 1 on the same cycle: the write happens immediately with io_rdata and the FSM stays in RUN.
  - WAIT_IO: `stall` = 1 and the counter increments each cycle.
    - io_rvalid = 1: rf_we fires with io_rdata (aligned), `stall` = 0 that cycle, next state RUN.
    - Counter = IO_TIMEOUT with io_rvalid = 0: rf_we fires with rf_wd = 0, `io_err` = 1, `stall` = 0, next state RUN.
    - io_rvalid takes priority over the timeout on the same cycle.
- **Stall source.** `stall` is asserted in WAIT_IO only, plus the single RUN cycle in which the IO-load entry condition is detected. `stall` is combinational.

## Timing
- **Reset.** rst_n = 0 immediately forces WB valid = 0, state = RUN and counter = 0. As a result rf_we = 0, stall = 0 and io_err = 0 during reset, and the other outputs are don't-care. Reset in mid-wait abandons the IO load without writing it.
- **Latency.** An instruction presented on `in_*` at edge N is written at edge N+1; rf_we is high during cycle N..N+1.
- **IO load.** The stall lasts k cycles, where k is the number of cycles until io_rvalid, at most IO_TIMEOUT+1. The next instruction enters on the edge that ends the final cycle.
- **Forwarding.** rf_we, rf_wa and rf_wd are valid combinationally in the WB cycle and double as the forwarding bus.
- **Ignored inputs.** io_rvalid is ignored unless an IO load is in WB.

## Test plan
- ADDI result: in_alu = 0x0000_0005, wb_sel = ALU, rd = 3 → next cycle rf_we = 1, rf_wa = 3, rf_wd = 5, stall = 0.
- LB:
  - dmem_dout = 0x80FF_7F01, mask = 0100, mask_un = 0 → rf_wd = 0xFFFF_FFFF.
  - Same data, mask = 1000 → rf_wd = 0xFFFF_FF80.
  - Same data, mask = 1000, mask_un = 1 → rf_wd = 0x0000_0080.
- LH/LHU: dmem_dout = 0x8001_7FFF, mask = 1100 → LH gives 0xFFFF_8001, LHU gives 0x0000_8001. Mask = 0000 → rf_wd = 0.
- JAL to x0: pc = 0x1000_0010, wb_sel = PC+4, rd = 0 → rf_we = 0. The same instruction with rd = 1 → rf_wd = 0x1000_0014.
- IO load, io_rvalid after 3 cycles with io_rdata = 0x1234_5678 and mask 1111:
  - stall is high for 3 cycles, then rf_we = 1 with 0x1234_5678.
  - The following ADDI is written exactly one cycle later.
- IO timeout with IO_TIMEOUT = 4 and io_rvalid never asserted → stall for 5 cycles, then rf_we = 1, rf_wd = 0, io_err pulses once. Asserting rst_n low during a second wait → no write and stall = 0 immediately.
